// File: rtl/kl_edp_pkg.sv
// kl_edp_pkg: shared types and CRAM/CTL field encodings for the KL10 EBOX
// execution data path (kl_edp) and its AD function unit (kl_edp_alu).
// Datapath words are numbered [0:35], bit 0 = MSB, as in the KL10 prints.
package kl_edp_pkg;

  localparam int unsigned WORD_W = 36;
  localparam int unsigned HALF_W = 18;

  typedef logic [0:WORD_W-1] word_t;

  // AD/ADX function (cramAD)
  typedef enum logic [5:0] {
    adA       = 6'd0,
    adB       = 6'd1,
    ad0S      = 6'd2,
    ad1S      = 6'd3,
    adAplusB  = 6'd4,
    adAminusB = 6'd5,
    adAplus1  = 6'd6,
    adAminus1 = 6'd7,
    adAplusA  = 6'd8,
    adAND     = 6'd9,
    adOR      = 6'd10,
    adXOR     = 6'd11,
    adNotA    = 6'd12
  } ad_func_e;

  // AD A-mux select (cramADA); codes 4-7 select zero
  typedef enum logic [2:0] {
    adaAR  = 3'd0,
    adaARX = 3'd1,
    adaMQ  = 3'd2,
    adaPC  = 3'd3
  } ada_e;

  // AD B-mux select (cramADB)
  typedef enum logic [1:0] {
    adbFM   = 2'd0,
    adbBRx2 = 2'd1,
    adbBR   = 2'd2,
    adbARx4 = 2'd3
  } adb_e;

  // AR half source (ctlARL_SEL / ctlARR_SEL); codes 8-15 select zero
  typedef enum logic [3:0] {
    arsARMM  = 4'd0,
    arsCACHE = 4'd1,
    arsAD    = 4'd2,
    arsEBUS  = 4'd3,
    arsSH    = 4'd4,
    arsADx2  = 4'd5,
    arsADX   = 4'd6,
    arsADsr2 = 4'd7
  } ar_sel_e;

  // ARX half source (ctlARXL_SEL / ctlARXR_SEL)
  typedef enum logic [2:0] {
    arxsHOLD   = 3'd0,
    arxsCACHE  = 3'd1,
    arxsAD     = 3'd2,
    arxsMQ     = 3'd3,
    arxsSH     = 3'd4,
    arxsADXx2  = 3'd5,
    arxsADX    = 3'd6,
    arxsADXsr2 = 3'd7
  } arx_sel_e;

  // CRAM AR / ARX fields (decoded elsewhere in the EBOX)
  typedef enum logic [2:0] {
    arHOLD = 3'd0, arAR = 3'd1, arCACHE = 3'd2, arAD = 3'd3
  } cram_ar_e;

  typedef enum logic [2:0] {
    arxHOLD = 3'd0, arxARX = 3'd1, arxCACHE = 3'd2, arxAD = 3'd3
  } cram_arx_e;

  typedef enum logic {brHOLD = 1'b0, brAR = 1'b1} cram_br_e;
  typedef enum logic {brxHOLD = 1'b0, brxARX = 1'b1} cram_brx_e;

  // FM address source (cramFMADR)
  typedef enum logic [2:0] {
    fmadrAC0 = 3'd0, fmadrAC1 = 3'd1, fmadrXR = 3'd2, fmadrVMA = 3'd3
  } cram_fmadr_e;

  // Join the left half of one word with the right half of another.
  function automatic word_t merge_halves(input word_t l, input word_t r);
    return {l[0:HALF_W-1], r[HALF_W:WORD_W-1]};
  endfunction

endpackage

// File: rtl/kl_edp_alu.sv
// kl_edp_alu: 36-bit AD function unit (used for both AD and ADX).
// Ports:
//   func   in  6   AD function code (ad_func_e)
//   a, b   in  36  A and B operands
//   cin    in  1   carry into bit 35
//   inh18  in  1   block carry 18->17
//   gen18  in  1   force carry 18->17 (wins over inh18)
//   result out 36  function result
//   cry0   out 1   carry out of bit 0 (arithmetic functions only)
//   ovf    out 1   carry out of bit 0 XOR carry out of bit 1
module kl_edp_alu
  import kl_edp_pkg::*;
(
  input  logic [5:0] func,
  input  word_t      a,
  input  word_t      b,
  input  logic       cin,
  input  logic       inh18,
  input  logic       gen18,
  output word_t      result,
  output logic       cry0,
  output logic       ovf
);

  word_t       x, y;
  logic        c35;
  logic        arith;
  logic [18:0] sum_r;   // bits 18..35 plus carry out of bit 18
  logic [17:0] sum_m;   // bits 1..17 plus carry out of bit 1
  logic        c17, cry1, bit0;

  // Operand selection; subtract and increment supply their own +1.
  always_comb begin
    x     = '0;
    y     = '0;
    c35   = 1'b0;
    arith = 1'b0;
    unique case (func)
      adAplusB:  begin x = a; y = b;  c35 = cin;  arith = 1'b1; end
      adAminusB: begin x = a; y = ~b; c35 = 1'b1; arith = 1'b1; end
      adAplus1:  begin x = a; y = '0; c35 = 1'b1; arith = 1'b1; end
      adAminus1: begin x = a; y = '1; c35 = cin;  arith = 1'b1; end
      adAplusA:  begin x = a; y = a;  c35 = cin;  arith = 1'b1; end
      default:   ;
    endcase
  end

  // The adder is split at the 18/17 boundary so the carry can be
  // inhibited or forced between halves; bit 0 is kept separate for cry1.
  always_comb begin
    sum_r = {1'b0, x[18:35]} + {1'b0, y[18:35]} + {18'b0, c35};
    c17   = gen18 | (~inh18 & sum_r[18]);
    sum_m = {1'b0, x[1:17]} + {1'b0, y[1:17]} + {17'b0, c17};
    cry1  = sum_m[17];
    bit0  = x[0] ^ y[0] ^ cry1;
  end

  always_comb begin
    result = '0;
    cry0   = 1'b0;
    ovf    = 1'b0;
    if (arith) begin
      result = {bit0, sum_m[16:0], sum_r[17:0]};
      cry0   = (x[0] & y[0]) | (cry1 & (x[0] ^ y[0]));
      ovf    = cry0 ^ cry1;
    end else begin
      unique case (func)
        adA:     result = a;
        adB:     result = b;
        ad0S:    result = '0;
        ad1S:    result = '1;
        adAND:   result = a & b;
        adOR:    result = a | b;
        adXOR:   result = a ^ b;
        adNotA:  result = ~a;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/kl_edp.sv
// kl_edp: KL10 EBOX execution data path. AR/ARX/MQ/BR/BRX registers, AD and
// ADX function units, fast memory (FM_BLOCKS AC blocks of 16 words) and EBUS
// drivers. Bits numbered [0:35], bit 0 = MSB.
// Ports:
//   masterClk, masterRstN              clock, async active-low reset
//   cramAD/ADA/ADB                     AD function and operand mux selects
//   cramAR/ARX/BR/BRX/FMADR            CRAM register fields
//   ctlARL_SEL/ARR_SEL                 AR half sources; ctlARXL/ARXR_SEL ARX
//   ctlAR*_LOAD, ctlAR*_CLR            AR field loads / synchronous clears
//   ctlARX_LOAD                        ARX whole-word load
//   ctlMQ_SEL, ctlMQM_SEL, ctlMQM_EN   MQ source control
//   ctlAD_CRY_36, ctlADX_CRY_36        carry-in to bit 35
//   ctlINH_CRY_18, ctlSPEC_GEN_CRY_18  AD carry 18 inhibit / force
//   ctlAD_TO_EBUS_L/R                  EBUS half drive enables
//   cacheData, ebusDataIn, shSH, vmaHeldOrPC, armmSCD, armmVMA  data sources
//   aprFM_BLOCK, aprFM_ADR             FM address
//   conFM_WRITE00_17/18_35             FM half-word write enables
//   AD, ADX, AR, ARX, MQ, BR, BRX, FM  datapath values
//   adCry0, adOvf                      AD carry out / overflow
//   ebusDataOut, ebusDrive             EBUS data and drive flag
module kl_edp
  import kl_edp_pkg::*;
#(
  parameter int unsigned FM_BLOCKS = 8
) (
  input  logic        masterClk,
  input  logic        masterRstN,
  input  logic [5:0]  cramAD,
  input  logic [2:0]  cramADA,
  input  logic [1:0]  cramADB,
  input  logic [2:0]  cramAR,
  input  logic [2:0]  cramARX,
  input  logic        cramBR,
  input  logic        cramBRX,
  input  logic [2:0]  cramFMADR,
  input  logic [3:0]  ctlARL_SEL,
  input  logic [3:0]  ctlARR_SEL,
  input  logic [2:0]  ctlARXL_SEL,
  input  logic [2:0]  ctlARXR_SEL,
  input  logic        ctlAR00to08_LOAD,
  input  logic        ctlAR09to17_LOAD,
  input  logic        ctlARR_LOAD,
  input  logic        ctlARX_LOAD,
  input  logic        ctlAR00to11_CLR,
  input  logic        ctlAR12to17_CLR,
  input  logic        ctlARR_CLR,
  input  logic [1:0]  ctlMQ_SEL,
  input  logic [1:0]  ctlMQM_SEL,
  input  logic        ctlMQM_EN,
  input  logic        ctlAD_CRY_36,
  input  logic        ctlADX_CRY_36,
  input  logic        ctlINH_CRY_18,
  input  logic        ctlSPEC_GEN_CRY_18,
  input  logic        ctlAD_TO_EBUS_L,
  input  logic        ctlAD_TO_EBUS_R,
  input  logic [0:35] cacheData,
  input  logic [0:35] ebusDataIn,
  input  logic [0:35] shSH,
  input  logic [0:35] vmaHeldOrPC,
  input  logic [0:8]  armmSCD,
  input  logic [0:4]  armmVMA,
  input  logic [2:0]  aprFM_BLOCK,
  input  logic [3:0]  aprFM_ADR,
  input  logic        conFM_WRITE00_17,
  input  logic        conFM_WRITE18_35,
  output logic [0:35] AD,
  output logic [0:35] ADX,
  output logic [0:35] AR,
  output logic [0:35] ARX,
  output logic [0:35] MQ,
  output logic [0:35] BR,
  output logic [0:35] BRX,
  output logic [0:35] FM,
  output logic        adCry0,
  output logic        adOvf,
  output logic [0:35] ebusDataOut,
  output logic        ebusDrive
);

  localparam int unsigned FM_DEPTH = FM_BLOCKS * 16;

  word_t       ad_a, ad_b;
  word_t       ar_src  [8];
  word_t       arx_src [8];
  word_t       arl_src, arr_src, arx_next, mq_next;
  word_t       fm_mem  [FM_DEPTH];
  logic [6:0]  fm_addr;
  logic [1:0]  unused_adx_flags;
  logic        unused_cram;

  // These CRAM fields are decoded upstream into the ctl* selects.
  assign unused_cram = ^{cramAR, cramARX, cramFMADR};

  // ---------------- AD / ADX ----------------
  always_comb begin
    unique case (cramADA)
      adaAR:   ad_a = AR;
      adaARX:  ad_a = ARX;
      adaMQ:   ad_a = MQ;
      adaPC:   ad_a = vmaHeldOrPC;
      default: ad_a = '0;
    endcase
  end

  always_comb begin
    unique case (cramADB)
      adbFM:   ad_b = FM;
      adbBRx2: ad_b = BR << 1;
      adbBR:   ad_b = BR;
      default: ad_b = AR << 2;
    endcase
  end

  kl_edp_alu u_ad (
    .func   (cramAD),
    .a      (ad_a),
    .b      (ad_b),
    .cin    (ctlAD_CRY_36),
    .inh18  (ctlINH_CRY_18),
    .gen18  (ctlSPEC_GEN_CRY_18),
    .result (AD),
    .cry0   (adCry0),
    .ovf    (adOvf)
  );

  kl_edp_alu u_adx (
    .func   (cramAD),
    .a      (ARX),
    .b      (BRX),
    .cin    (ctlADX_CRY_36),
    .inh18  (1'b0),
    .gen18  (1'b0),
    .result (ADX),
    .cry0   (unused_adx_flags[0]),
    .ovf    (unused_adx_flags[1])
  );

  // ---------------- AR / ARX source muxes ----------------
  always_comb begin
    ar_src[arsARMM]  = {armmSCD, 4'b0, armmVMA, 18'b0};
    ar_src[arsCACHE] = cacheData;
    ar_src[arsAD]    = AD;
    ar_src[arsEBUS]  = ebusDataIn;
    ar_src[arsSH]    = shSH;
    ar_src[arsADx2]  = AD << 1;
    ar_src[arsADX]   = ADX;
    ar_src[arsADsr2] = AD >> 2;

    arx_src[arxsHOLD]   = ARX;
    arx_src[arxsCACHE]  = cacheData;
    arx_src[arxsAD]     = AD;
    arx_src[arxsMQ]     = MQ;
    arx_src[arxsSH]     = shSH;
    arx_src[arxsADXx2]  = ADX << 1;
    arx_src[arxsADX]    = ADX;
    arx_src[arxsADXsr2] = ADX >> 2;
  end

  assign arl_src  = ctlARL_SEL[3] ? '0 : ar_src[ctlARL_SEL[2:0]];
  assign arr_src  = ctlARR_SEL[3] ? '0 : ar_src[ctlARR_SEL[2:0]];
  assign arx_next = merge_halves(arx_src[ctlARXL_SEL], arx_src[ctlARXR_SEL]);

  // ---------------- MQ source ----------------
  always_comb begin
    mq_next = MQ;
    if (ctlMQM_EN) begin
      unique case (ctlMQM_SEL)
        2'd0:    mq_next = '0;
        2'd1:    mq_next = shSH;
        2'd2:    mq_next = AD;
        default: mq_next = {ADX[34:35], MQ[0:33]};
      endcase
    end else begin
      unique case (ctlMQ_SEL)
        2'd0:    mq_next = MQ;
        2'd1:    mq_next = shSH;
        2'd2:    mq_next = AD;
        default: mq_next = '1;
      endcase
    end
  end

  // ---------------- Registers ----------------
  // AR clear fields ([0:11],[12:17]) straddle the load fields ([0:8],[9:17]),
  // so bits 9-11 are written separately to give each clear priority.
  always_ff @(posedge masterClk or negedge masterRstN) begin
    if (!masterRstN) begin
      AR  <= '0;
      ARX <= '0;
      MQ  <= '0;
      BR  <= '0;
      BRX <= '0;
    end else begin
      if (ctlAR00to11_CLR)       AR[0:8] <= '0;
      else if (ctlAR00to08_LOAD) AR[0:8] <= arl_src[0:8];

      if (ctlAR00to11_CLR)       AR[9:11] <= '0;
      else if (ctlAR09to17_LOAD) AR[9:11] <= arl_src[9:11];

      if (ctlAR12to17_CLR)       AR[12:17] <= '0;
      else if (ctlAR09to17_LOAD) AR[12:17] <= arl_src[12:17];

      if (ctlARR_CLR)            AR[18:35] <= '0;
      else if (ctlARR_LOAD)      AR[18:35] <= arr_src[18:35];

      if (ctlARX_LOAD)      ARX <= arx_next;
      MQ <= mq_next;
      if (cramBR == brAR)   BR  <= AR;
      if (cramBRX == brxARX) BRX <= ARX;
    end
  end

  // ---------------- Fast memory ----------------
  assign fm_addr = {aprFM_BLOCK, aprFM_ADR};
  assign FM      = fm_mem[fm_addr];

  always_ff @(posedge masterClk) begin
    if (conFM_WRITE00_17) fm_mem[fm_addr][0:17]  <= AR[0:17];
    if (conFM_WRITE18_35) fm_mem[fm_addr][18:35] <= AR[18:35];
  end

  // ---------------- EBUS ----------------
  assign ebusDataOut = {ctlAD_TO_EBUS_L ? AD[0:17]  : 18'b0,
                        ctlAD_TO_EBUS_R ? AD[18:35] : 18'b0};
  assign ebusDrive   = ctlAD_TO_EBUS_L | ctlAD_TO_EBUS_R;

endmodule

// File: tb/tb_kl_edp.sv
// tb_kl_edp: self-checking bench for kl_edp. A word-level model tracks the
// registers and FM; every falling clock edge all outputs are compared with it.
// Literal checks at key points pin the model to hand-worked values.
module tb_kl_edp;
  import kl_edp_pkg::*;

  logic        masterClk = 1'b0;
  logic        masterRstN;
  logic [5:0]  cramAD;
  logic [2:0]  cramADA, cramAR, cramARX, cramFMADR;
  logic [1:0]  cramADB;
  logic        cramBR, cramBRX;
  logic [3:0]  ctlARL_SEL, ctlARR_SEL;
  logic [2:0]  ctlARXL_SEL, ctlARXR_SEL;
  logic        ctlAR00to08_LOAD, ctlAR09to17_LOAD, ctlARR_LOAD, ctlARX_LOAD;
  logic        ctlAR00to11_CLR, ctlAR12to17_CLR, ctlARR_CLR;
  logic [1:0]  ctlMQ_SEL, ctlMQM_SEL;
  logic        ctlMQM_EN, ctlAD_CRY_36, ctlADX_CRY_36;
  logic        ctlINH_CRY_18, ctlSPEC_GEN_CRY_18;
  logic        ctlAD_TO_EBUS_L, ctlAD_TO_EBUS_R;
  logic [35:0] cacheData, ebusDataIn, shSH, vmaHeldOrPC;
  logic [8:0]  armmSCD;
  logic [4:0]  armmVMA;
  logic [2:0]  aprFM_BLOCK;
  logic [3:0]  aprFM_ADR;
  logic        conFM_WRITE00_17, conFM_WRITE18_35;
  logic [35:0] AD, ADX, AR, ARX, MQ, BR, BRX, FM, ebusDataOut;
  logic        adCry0, adOvf, ebusDrive;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic        chk_en = 1'b0;

  logic [35:0] m_ar, m_arx, m_mq, m_br, m_brx;
  logic [35:0] m_fm [128];

  always #5 masterClk = ~masterClk;

  kl_edp #(.FM_BLOCKS(8)) dut (
    .masterClk(masterClk), .masterRstN(masterRstN),
    .cramAD(cramAD), .cramADA(cramADA), .cramADB(cramADB),
    .cramAR(cramAR), .cramARX(cramARX), .cramBR(cramBR), .cramBRX(cramBRX),
    .cramFMADR(cramFMADR),
    .ctlARL_SEL(ctlARL_SEL), .ctlARR_SEL(ctlARR_SEL),
    .ctlARXL_SEL(ctlARXL_SEL), .ctlARXR_SEL(ctlARXR_SEL),
    .ctlAR00to08_LOAD(ctlAR00to08_LOAD), .ctlAR09to17_LOAD(ctlAR09to17_LOAD),
    .ctlARR_LOAD(ctlARR_LOAD), .ctlARX_LOAD(ctlARX_LOAD),
    .ctlAR00to11_CLR(ctlAR00to11_CLR), .ctlAR12to17_CLR(ctlAR12to17_CLR),
    .ctlARR_CLR(ctlARR_CLR),
    .ctlMQ_SEL(ctlMQ_SEL), .ctlMQM_SEL(ctlMQM_SEL), .ctlMQM_EN(ctlMQM_EN),
    .ctlAD_CRY_36(ctlAD_CRY_36), .ctlADX_CRY_36(ctlADX_CRY_36),
    .ctlINH_CRY_18(ctlINH_CRY_18), .ctlSPEC_GEN_CRY_18(ctlSPEC_GEN_CRY_18),
    .ctlAD_TO_EBUS_L(ctlAD_TO_EBUS_L), .ctlAD_TO_EBUS_R(ctlAD_TO_EBUS_R),
    .cacheData(cacheData), .ebusDataIn(ebusDataIn), .shSH(shSH),
    .vmaHeldOrPC(vmaHeldOrPC), .armmSCD(armmSCD), .armmVMA(armmVMA),
    .aprFM_BLOCK(aprFM_BLOCK), .aprFM_ADR(aprFM_ADR),
    .conFM_WRITE00_17(conFM_WRITE00_17), .conFM_WRITE18_35(conFM_WRITE18_35),
    .AD(AD), .ADX(ADX), .AR(AR), .ARX(ARX), .MQ(MQ), .BR(BR), .BRX(BRX),
    .FM(FM), .adCry0(adCry0), .adOvf(adOvf),
    .ebusDataOut(ebusDataOut), .ebusDrive(ebusDrive)
  );

  task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Two's-complement add of 36-bit words with the carry into the left half
  // replaceable; returns the sum, carry out of bit 0 and out of bit 1.
  function automatic logic [35:0] add36(input logic [35:0] a, input logic [35:0] b,
                                        input logic cin, input logic inh, input logic gen,
                                        output logic c0, output logic c1);
    logic [63:0] r, l, m;
    logic        c18;
    r   = 64'(a[17:0]) + 64'(b[17:0]) + 64'(cin);
    c18 = gen ? 1'b1 : (inh ? 1'b0 : r[18]);
    l   = 64'(a[35:18]) + 64'(b[35:18]) + 64'(c18);
    m   = 64'(a[34:18]) + 64'(b[34:18]) + 64'(c18);
    c0  = l[18];
    c1  = m[17];
    return {l[17:0], r[17:0]};
  endfunction

  function automatic logic [35:0] f_ad(input logic [5:0] fn, input logic [35:0] a,
                                       input logic [35:0] b, input logic cin,
                                       input logic inh, input logic gen,
                                       output logic cry0, output logic ovf);
    logic [35:0] res;
    logic        c0, c1;
    c0 = 1'b0; c1 = 1'b0;
    case (fn)
      6'd0:  res = a;
      6'd1:  res = b;
      6'd2:  res = 36'h0;
      6'd3:  res = 36'hFFFFFFFFF;
      6'd4:  res = add36(a, b, cin, inh, gen, c0, c1);
      6'd5:  res = add36(a, ~b, 1'b1, inh, gen, c0, c1);
      6'd6:  res = add36(a, 36'h0, 1'b1, inh, gen, c0, c1);
      6'd7:  res = add36(a, 36'hFFFFFFFFF, cin, inh, gen, c0, c1);
      6'd8:  res = add36(a, a, cin, inh, gen, c0, c1);
      6'd9:  res = a & b;
      6'd10: res = a | b;
      6'd11: res = a ^ b;
      6'd12: res = ~a;
      default: res = 36'h0;
    endcase
    cry0 = c0;
    ovf  = c0 ^ c1;
    return res;
  endfunction

  task automatic model_comb(output logic [35:0] ad, output logic [35:0] adx,
                            output logic cry0, output logic ovf);
    logic [35:0] a, b;
    logic        d0, d1;
    case (cramADA)
      3'd0: a = m_ar;
      3'd1: a = m_arx;
      3'd2: a = m_mq;
      3'd3: a = vmaHeldOrPC;
      default: a = 36'h0;
    endcase
    case (cramADB)
      2'd0: b = m_fm[{aprFM_BLOCK, aprFM_ADR}];
      2'd1: b = {m_br[34:0], 1'b0};
      2'd2: b = m_br;
      default: b = {m_ar[33:0], 2'b00};
    endcase
    ad  = f_ad(cramAD, a, b, ctlAD_CRY_36, ctlINH_CRY_18, ctlSPEC_GEN_CRY_18, cry0, ovf);
    adx = f_ad(cramAD, m_arx, m_brx, ctlADX_CRY_36, 1'b0, 1'b0, d0, d1);
  endtask

  function automatic logic [35:0] ar_srcm(input logic [3:0] sel, input logic [35:0] ad,
                                          input logic [35:0] adx);
    case (sel)
      4'd0: return {armmSCD, 4'b0, armmVMA, 18'b0};
      4'd1: return cacheData;
      4'd2: return ad;
      4'd3: return ebusDataIn;
      4'd4: return shSH;
      4'd5: return {ad[34:0], 1'b0};
      4'd6: return adx;
      4'd7: return {2'b00, ad[35:2]};
      default: return 36'h0;
    endcase
  endfunction

  function automatic logic [35:0] arx_srcm(input logic [2:0] sel, input logic [35:0] ad,
                                           input logic [35:0] adx);
    case (sel)
      3'd0: return m_arx;
      3'd1: return cacheData;
      3'd2: return ad;
      3'd3: return m_mq;
      3'd4: return shSH;
      3'd5: return {adx[34:0], 1'b0};
      3'd6: return adx;
      default: return {2'b00, adx[35:2]};
    endcase
  endfunction

  always @(posedge masterClk or negedge masterRstN) begin
    logic [35:0] ad, adx, arl, arr, xl, xr, nar, narx, nmq;
    logic        c0, ov, clr, ld;
    if (!masterRstN) begin
      m_ar <= '0; m_arx <= '0; m_mq <= '0; m_br <= '0; m_brx <= '0;
    end else begin
      model_comb(ad, adx, c0, ov);
      arl = ar_srcm(ctlARL_SEL, ad, adx);
      arr = ar_srcm(ctlARR_SEL, ad, adx);
      nar = m_ar;
      for (int i = 0; i < 36; i++) begin   // i = PDP-10 bit number
        clr = (i <= 11) ? ctlAR00to11_CLR : (i <= 17) ? ctlAR12to17_CLR : ctlARR_CLR;
        ld  = (i <= 8) ? ctlAR00to08_LOAD : (i <= 17) ? ctlAR09to17_LOAD : ctlARR_LOAD;
        if (clr)     nar[35-i] = 1'b0;
        else if (ld) nar[35-i] = (i <= 17) ? arl[35-i] : arr[35-i];
      end
      xl   = arx_srcm(ctlARXL_SEL, ad, adx);
      xr   = arx_srcm(ctlARXR_SEL, ad, adx);
      narx = ctlARX_LOAD ? {xl[35:18], xr[17:0]} : m_arx;
      if (!ctlMQM_EN)
        case (ctlMQ_SEL)
          2'd0: nmq = m_mq;
          2'd1: nmq = shSH;
          2'd2: nmq = ad;
          default: nmq = 36'hFFFFFFFFF;
        endcase
      else
        case (ctlMQM_SEL)
          2'd0: nmq = 36'h0;
          2'd1: nmq = shSH;
          2'd2: nmq = ad;
          default: nmq = {adx[1:0], m_mq[35:2]};
        endcase
      if (conFM_WRITE00_17) m_fm[{aprFM_BLOCK, aprFM_ADR}][35:18] <= m_ar[35:18];
      if (conFM_WRITE18_35) m_fm[{aprFM_BLOCK, aprFM_ADR}][17:0]  <= m_ar[17:0];
      if (cramBR)  m_br  <= m_ar;
      if (cramBRX) m_brx <= m_arx;
      m_ar  <= nar;
      m_arx <= narx;
      m_mq  <= nmq;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge masterClk) begin
    logic [35:0] e_ad, e_adx;
    logic        e_c0, e_ov;
    if (chk_en) begin
      model_comb(e_ad, e_adx, e_c0, e_ov);
      cmp("AD", AD, e_ad);
      cmp("ADX", ADX, e_adx);
      cmp("adCry0", 36'(adCry0), 36'(e_c0));
      cmp("adOvf", 36'(adOvf), 36'(e_ov));
      cmp("AR", AR, m_ar);
      cmp("ARX", ARX, m_arx);
      cmp("MQ", MQ, m_mq);
      cmp("BR", BR, m_br);
      cmp("BRX", BRX, m_brx);
      cmp("FM", FM, m_fm[{aprFM_BLOCK, aprFM_ADR}]);
      cmp("ebusDataOut", ebusDataOut,
          {ctlAD_TO_EBUS_L ? e_ad[35:18] : 18'h0, ctlAD_TO_EBUS_R ? e_ad[17:0] : 18'h0});
      cmp("ebusDrive", 36'(ebusDrive), 36'(ctlAD_TO_EBUS_L | ctlAD_TO_EBUS_R));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge masterClk);
    #1;
  endtask

  task automatic clear_ctl();
    cramAD = '0; cramADA = '0; cramADB = '0; cramAR = '0; cramARX = '0;
    cramBR = 1'b0; cramBRX = 1'b0; cramFMADR = '0;
    ctlARL_SEL = '0; ctlARR_SEL = '0; ctlARXL_SEL = '0; ctlARXR_SEL = '0;
    ctlAR00to08_LOAD = 1'b0; ctlAR09to17_LOAD = 1'b0; ctlARR_LOAD = 1'b0;
    ctlARX_LOAD = 1'b0; ctlAR00to11_CLR = 1'b0; ctlAR12to17_CLR = 1'b0;
    ctlARR_CLR = 1'b0; ctlMQ_SEL = '0; ctlMQM_SEL = '0; ctlMQM_EN = 1'b0;
    ctlAD_CRY_36 = 1'b0; ctlADX_CRY_36 = 1'b0; ctlINH_CRY_18 = 1'b0;
    ctlSPEC_GEN_CRY_18 = 1'b0; ctlAD_TO_EBUS_L = 1'b0; ctlAD_TO_EBUS_R = 1'b0;
    conFM_WRITE00_17 = 1'b0; conFM_WRITE18_35 = 1'b0;
  endtask

  task automatic ld_ar(input logic [35:0] v);
    cacheData = v; ctlARL_SEL = 4'd1; ctlARR_SEL = 4'd1;
    ctlAR00to08_LOAD = 1'b1; ctlAR09to17_LOAD = 1'b1; ctlARR_LOAD = 1'b1;
    tick();
    ctlAR00to08_LOAD = 1'b0; ctlAR09to17_LOAD = 1'b0; ctlARR_LOAD = 1'b0;
    ctlARL_SEL = 4'd0; ctlARR_SEL = 4'd0;
  endtask

  initial begin
    masterRstN = 1'b0;
    clear_ctl();
    cacheData = '0; ebusDataIn = '0; shSH = '0; vmaHeldOrPC = '0;
    armmSCD = '0; armmVMA = '0; aprFM_BLOCK = '0; aprFM_ADR = '0;

    // reset with clock running; try to load AR meanwhile
    cacheData = 36'h555555555; ctlARL_SEL = 4'd1; ctlARR_SEL = 4'd1;
    ctlAR00to08_LOAD = 1'b1; ctlAR09to17_LOAD = 1'b1; ctlARR_LOAD = 1'b1;
    repeat (3) @(posedge masterClk);
    #1;
    cmp("rst_AR", AR, 36'h0);
    cmp("rst_ARX", ARX, 36'h0);
    cmp("rst_MQ", MQ, 36'h0);
    cmp("rst_BR", BR, 36'h0);
    cmp("rst_BRX", BRX, 36'h0);
    cmp("rst_ebusDrive", 36'(ebusDrive), 36'h0);
    clear_ctl();
    masterRstN = 1'b1;

    // give every FM word a known value (AR is zero)
    conFM_WRITE00_17 = 1'b1; conFM_WRITE18_35 = 1'b1;
    for (int a = 0; a < 128; a++) begin
      {aprFM_BLOCK, aprFM_ADR} = 7'(a);
      tick();
    end
    conFM_WRITE00_17 = 1'b0; conFM_WRITE18_35 = 1'b0;
    {aprFM_BLOCK, aprFM_ADR} = 7'd0;
    chk_en = 1'b1;

    // all-ones load through the cache path
    ld_ar(36'hFFFFFFFFF);
    cmp("lit_AR_ones", AR, 36'hFFFFFFFFF);
    cramAD = adA; cramADA = adaAR; #1;
    cmp("lit_AD_A", AD, 36'hFFFFFFFFF);

    // AR + BR with BR copied from AR
    ld_ar(36'h987654321);
    cramBR = 1'b1; tick(); cramBR = 1'b0;
    cramAD = adAplusB; cramADA = adaAR; cramADB = adbBR; #1;
    cmp("lit_AD_sum", AD, 36'h30ECA8642);
    cmp("lit_adCry0", 36'(adCry0), 36'h1);
    cmp("lit_adOvf", 36'(adOvf), 36'h1);
    ctlAD_TO_EBUS_L = 1'b1; #1;
    cmp("lit_ebusL", ebusDataOut, 36'h30EC80000);
    cmp("lit_ebusDrive", 36'(ebusDrive), 36'h1);
    tick();
    ctlAD_TO_EBUS_L = 1'b0;
    cramAD = ad0S; #1;
    cmp("lit_AD_0S", AD, 36'h0);

    // carry 18 -> 17 inhibit on A+1
    ld_ar(36'h0003FFFFF);
    cramAD = adAplus1; cramADA = adaAR; ctlINH_CRY_18 = 1'b1; #1;
    cmp("lit_inh18", AD, 36'h0003C0000);
    tick();
    ctlINH_CRY_18 = 1'b0; #1;
    cmp("lit_cry18", AD, 36'h000400000);
    tick();

    // right clear beats right load; left half still loads
    cacheData = 36'h123456789; ctlARL_SEL = 4'd1; ctlARR_SEL = 4'd1;
    ctlAR00to08_LOAD = 1'b1; ctlAR09to17_LOAD = 1'b1; ctlARR_LOAD = 1'b1;
    ctlARR_CLR = 1'b1;
    tick();
    clear_ctl();
    cmp("lit_arr_clr", AR, 36'h123440000);

    // FM write at block 0 AC7, then read back and use as B operand
    ld_ar(36'h123456789);
    aprFM_BLOCK = 3'd0; aprFM_ADR = 4'd7;
    conFM_WRITE00_17 = 1'b1; conFM_WRITE18_35 = 1'b1; #1;
    cmp("lit_fm_old", FM, 36'h0);
    tick();
    conFM_WRITE00_17 = 1'b0; conFM_WRITE18_35 = 1'b0; #1;
    cmp("lit_fm_rd", FM, 36'h123456789);
    cramAD = adAplusB; cramADA = adaAR; cramADB = adbFM; #1;
    cmp("lit_AD_fm", AD, 36'h2468ACF12);
    tick();

    // MQ ones, then shift right 2 with ADX[34:35] = 01 (ARX=BRX=0, A+1)
    cramAD = adA; ctlMQ_SEL = 2'd3; tick(); ctlMQ_SEL = 2'd0;
    cmp("lit_MQ_ones", MQ, 36'hFFFFFFFFF);
    cramAD = adAplus1; ctlMQM_EN = 1'b1; ctlMQM_SEL = 2'd3; #1;
    cmp("lit_ADX_inc", ADX, 36'h000000001);
    tick();
    ctlMQM_EN = 1'b0; ctlMQM_SEL = 2'd0;
    cmp("lit_MQ_shift", MQ, 36'h7FFFFFFFF);

    // directed sweep of functions, muxes and control combinations
    shSH = 36'hA5A5A5A5A; ebusDataIn = 36'h3C3C3C3C3;
    vmaHeldOrPC = 36'h000123456; armmSCD = 9'h1A5; armmVMA = 5'h13;
    for (int i = 0; i < 26; i++) begin
      cramAD = 6'(i % 14);
      cramADA = 3'(i % 5);
      cramADB = 2'((i / 2) % 4);
      aprFM_ADR = 4'(i % 8);
      ctlARL_SEL = 4'((i * 3) % 11);
      ctlARR_SEL = 4'((i + 5) % 10);
      ctlARXL_SEL = 3'(i % 8);
      ctlARXR_SEL = 3'((i + 3) % 8);
      ctlAR00to08_LOAD = 1'(i % 2 == 0);
      ctlAR09to17_LOAD = 1'(i % 3 != 1);
      ctlARR_LOAD = 1'(i % 4 != 3);
      ctlARX_LOAD = 1'(i % 3 != 2);
      ctlAR00to11_CLR = 1'(i == 4 || i == 17);
      ctlAR12to17_CLR = 1'(i == 7 || i == 20);
      ctlARR_CLR = 1'(i == 11);
      cramBR = 1'(i % 2);
      cramBRX = 1'(i % 3 == 0);
      ctlMQM_EN = 1'(i % 4 == 1);
      ctlMQ_SEL = 2'(i % 4);
      ctlMQM_SEL = 2'((i / 4) % 4);
      ctlAD_CRY_36 = 1'(i % 2);
      ctlADX_CRY_36 = 1'(i % 3 == 1);
      ctlINH_CRY_18 = 1'(i % 3 == 0);
      ctlSPEC_GEN_CRY_18 = 1'(i % 5 == 0);
      ctlAD_TO_EBUS_L = 1'(i % 2);
      ctlAD_TO_EBUS_R = 1'(i % 3 == 0);
      conFM_WRITE00_17 = 1'(i % 5 == 2);
      conFM_WRITE18_35 = 1'(i % 7 == 3);
      cacheData = 36'h0F0F0F0F0 ^ (36'(i) * 36'h111111111);
      tick();
    end
    clear_ctl();
    tick();

    // asynchronous reset in the middle of a cycle
    ld_ar(36'hDEADBEEF1);
    #3 masterRstN = 1'b0;
    #1;
    cmp("async_rst_AR", AR, 36'h0);
    cmp("async_rst_MQ", MQ, 36'h0);
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
